// File: rtl/fp_cmp_pkg.sv
// Shared encodings for the FloPoCo comparator: exception classes, predicate codes
// and the class-ordering helper used by the compare pipeline.
package fp_cmp_pkg;

    typedef enum logic [1:0] {
        EXC_ZERO   = 2'b00,
        EXC_NORMAL = 2'b01,
        EXC_INF    = 2'b10,
        EXC_NAN    = 2'b11
    } exc_t;

    localparam logic [2:0] OP_GE = 3'd0;
    localparam logic [2:0] OP_GT = 3'd1;
    localparam logic [2:0] OP_LE = 3'd2;
    localparam logic [2:0] OP_LT = 3'd3;
    localparam logic [2:0] OP_EQ = 3'd4;
    localparam logic [2:0] OP_NE = 3'd5;

    // Coarse rank: -inf < -normal < zero < +normal < +inf (NaN handled separately).
    function automatic logic [2:0] class_rank(input exc_t exc, input logic sign);
        logic [2:0] rank;
        case (exc)
            EXC_ZERO:   rank = 3'd2;
            EXC_NORMAL: rank = sign ? 3'd1 : 3'd3;
            EXC_INF:    rank = sign ? 3'd0 : 3'd4;
            default:    rank = 3'd2;
        endcase
        return rank;
    endfunction

endpackage

// File: rtl/fp_compare_pipe_classify.sv
// Operand field decoder: splits a FloPoCo word into exception class, sign and
// the {exponent, fraction} magnitude used for same-class ordering.
module fp_classify
    import fp_cmp_pkg::*;
#(
    parameter int WE = 11,
    parameter int WF = 14
) (
    input  logic [WE+WF+2:0] x,
    output exc_t             exc,
    output logic             sign,
    output logic [WE+WF-1:0] mag
);

    always_comb begin
        exc  = exc_t'(x[WE+WF+2:WE+WF+1]);
        sign = x[WE+WF];
        mag  = x[WE+WF-1:0];
    end

endmodule

// File: rtl/fp_compare_pipe.sv
// Two-stage FloPoCo floating-point predicate unit with valid/ready handshaking.
// Optional macro FPCMP_UNORD_FLAG_EN adds the out_unord NaN indicator output.
module fp_compare_pipe
    import fp_cmp_pkg::*;
#(
    parameter int WE = 11,
    parameter int WF = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WE+WF+2:0] in_a,
    input  logic [WE+WF+2:0] in_b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef FPCMP_UNORD_FLAG_EN
    output logic             out_result,
    output logic             out_unord
`else
    output logic             out_result
`endif
);

    exc_t             exc_a, exc_b;
    logic             sign_a, sign_b;
    logic [WE+WF-1:0] mag_a, mag_b;

    fp_classify #(.WE(WE), .WF(WF)) u_class_a (
        .x    (in_a),
        .exc  (exc_a),
        .sign (sign_a),
        .mag  (mag_a)
    );

    fp_classify #(.WE(WE), .WF(WF)) u_class_b (
        .x    (in_b),
        .exc  (exc_b),
        .sign (sign_b),
        .mag  (mag_b)
    );

    // Stage 1: classification and magnitude compares
    logic       s1_valid;
    exc_t       s1_exc_a, s1_exc_b;
    logic       s1_sign_a, s1_sign_b;
    logic       s1_mag_gt, s1_mag_eq;
    logic [2:0] s1_op;

    // Stage 2: predicate outcome
    logic       s2_valid;
    logic       s2_result;
    logic       s2_unord;

    logic       s1_advance;
    logic       s1_load;

    always_comb begin
        s1_advance = s1_valid && (!s2_valid || out_ready);
        in_ready   = !s1_valid || s1_advance;
        s1_load    = in_valid && in_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_exc_a  <= EXC_ZERO;
            s1_exc_b  <= EXC_ZERO;
            s1_sign_a <= 1'b0;
            s1_sign_b <= 1'b0;
            s1_mag_gt <= 1'b0;
            s1_mag_eq <= 1'b0;
            s1_op     <= '0;
        end else begin
            if (s1_load) begin
                s1_valid  <= 1'b1;
                s1_exc_a  <= exc_a;
                s1_exc_b  <= exc_b;
                s1_sign_a <= sign_a;
                s1_sign_b <= sign_b;
                s1_mag_gt <= (mag_a > mag_b);
                s1_mag_eq <= (mag_a == mag_b);
                s1_op     <= op;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

    logic [2:0] rank_a, rank_b;
    logic       unord;
    logic       a_lt, a_eq;
    logic       pred;
    logic       result;

    always_comb begin
        rank_a = class_rank(s1_exc_a, s1_sign_a);
        rank_b = class_rank(s1_exc_b, s1_sign_b);
        unord  = (s1_exc_a == EXC_NAN) || (s1_exc_b == EXC_NAN);

        // Equal rank only needs magnitudes when both are normals of the same sign;
        // for negatives the larger magnitude is the smaller value.
        a_eq = 1'b0;
        a_lt = 1'b0;
        if (rank_a < rank_b) begin
            a_lt = 1'b1;
        end else if (rank_a == rank_b) begin
            if (rank_a == 3'd3) begin
                a_eq = s1_mag_eq;
                a_lt = !s1_mag_gt && !s1_mag_eq;
            end else if (rank_a == 3'd1) begin
                a_eq = s1_mag_eq;
                a_lt = s1_mag_gt;
            end else begin
                a_eq = 1'b1;
            end
        end

        case (s1_op)
            OP_GE:   pred = !a_lt;
            OP_GT:   pred = !a_lt && !a_eq;
            OP_LE:   pred = a_lt || a_eq;
            OP_LT:   pred = a_lt;
            OP_EQ:   pred = a_eq;
            OP_NE:   pred = !a_eq;
            default: pred = 1'b0;
        endcase

        result = unord ? (s1_op == OP_NE) : pred;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid  <= 1'b0;
            s2_result <= 1'b0;
            s2_unord  <= 1'b0;
        end else begin
            if (s1_advance) begin
                s2_valid  <= 1'b1;
                s2_result <= result;
                s2_unord  <= unord;
            end else if (out_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        out_valid  = s2_valid;
        out_result = s2_result;
    end

`ifdef FPCMP_UNORD_FLAG_EN
    always_comb out_unord = s2_unord;
`else
    logic unused_unord;
    always_comb unused_unord = s2_unord;
`endif

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Self-checking bench for fp_compare_pipe: directed spec cases, stall/order and
// reset checks, then randomized traffic against a value-ordering reference model.
module tb_fp_compare_pipe;

    localparam int WE = 11;
    localparam int WF = 14;
    localparam int W  = WE + WF + 3;

    localparam logic [W-1:0] ONE   = 28'h4FFC000;
    localparam logic [W-1:0] TWO   = 28'h5000000;
    localparam logic [W-1:0] M_ONE = 28'h6FFC000;
    localparam logic [W-1:0] P_Z   = 28'h0000000;
    localparam logic [W-1:0] M_Z   = 28'h2000000;
    localparam logic [W-1:0] P_INF = 28'h8000000;
    localparam logic [W-1:0] NAN   = 28'hC000000;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic         out_result;
`ifdef FPCMP_UNORD_FLAG_EN
    logic         out_unord;
`endif

    fp_compare_pipe #(.WE(WE), .WF(WF)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
`ifdef FPCMP_UNORD_FLAG_EN
        .out_result (out_result),
        .out_unord  (out_unord)
`else
        .out_result (out_result)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic res;
        logic unord;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic last_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: map each non-NaN operand to a signed integer on the real line.
    function automatic longint value_key(input logic [W-1:0] x);
        longint m;
        longint big;
        m   = longint'(x[WE+WF-1:0]);
        big = (longint'(1) << (WE + WF)) + 1;
        case (x[W-1:W-2])
            2'b00:   return 0;
            2'b01:   return x[W-3] ? -(m + 1) : (m + 1);
            default: return x[W-3] ? -big : big;
        endcase
    endfunction

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] o);
        exp_t   e;
        longint ka, kb;
        e.unord = (a[W-1:W-2] == 2'b11) || (b[W-1:W-2] == 2'b11);
        ka = value_key(a);
        kb = value_key(b);
        if (e.unord) e.res = (o == 3'd5);
        else begin
            case (o)
                3'd0:    e.res = (ka >= kb);
                3'd1:    e.res = (ka > kb);
                3'd2:    e.res = (ka <= kb);
                3'd3:    e.res = (ka < kb);
                3'd4:    e.res = (ka == kb);
                3'd5:    e.res = (ka != kb);
                default: e.res = 1'b0;
            endcase
        end
        return e;
    endfunction

    // One clock: score the output handshake and log accepted inputs, then advance.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", 32'(out_result), 32'(e.res));
`ifdef FPCMP_UNORD_FLAG_EN
                check("unord", 32'(out_unord), 32'(e.unord));
`endif
            end
        end
        last_acc = in_valid && in_ready;
        if (last_acc) exp_q.push_back(model(in_a, in_b, op));
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [2:0] o, input logic exp_res);
        out_ready = 1'b1;
        in_a = a; in_b = b; op = o; in_valid = 1'b1;
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        cycle();
        in_valid = 1'b0;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        cycle();
        check({tag, "_lat2"}, 32'(out_valid), 32'd1);
        check(tag, 32'(out_result), 32'(exp_res));
`ifdef FPCMP_UNORD_FLAG_EN
        check({tag, "_unord"}, 32'(out_unord), 32'((a[W-1:W-2] == 2'b11) || (b[W-1:W-2] == 2'b11)));
`endif
        cycle();
    endtask

    function automatic logic [W-1:0] rand_operand();
        logic [W-1:0] x;
        int r;
        x = W'({$urandom, $urandom});
        r = int'($urandom_range(0, 9));
        x[W-1:W-2] = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b01;
        if ($urandom_range(0, 1) == 1) x[WE+WF-1:WF] = WE'(1022 + $urandom_range(0, 2));
        if ($urandom_range(0, 2) == 0) x[WF-1:0] = WF'($urandom_range(0, 3));
        return x;
    endfunction

    logic held;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; op = '0; last_acc = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", 32'(out_result), 32'd0);
`ifdef FPCMP_UNORD_FLAG_EN
        check("rst_out_unord", 32'(out_unord), 32'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        send_one("two_ge_one", TWO, ONE, 3'd0, 1'b1);
        send_one("two_lt_one", TWO, ONE, 3'd3, 1'b0);
        send_one("pz_eq_mz", P_Z, M_Z, 3'd4, 1'b1);
        send_one("pz_gt_mz", P_Z, M_Z, 3'd1, 1'b0);
        send_one("pz_ge_mz", P_Z, M_Z, 3'd0, 1'b1);
        send_one("nan_ge", NAN, ONE, 3'd0, 1'b0);
        send_one("nan_lt", NAN, ONE, 3'd3, 1'b0);
        send_one("nan_eq", NAN, ONE, 3'd4, 1'b0);
        send_one("nan_ne", NAN, ONE, 3'd5, 1'b1);
        send_one("m1_lt_inf", M_ONE, P_INF, 3'd3, 1'b1);
        send_one("inf_ge_inf", P_INF, P_INF, 3'd0, 1'b1);
        send_one("op6_zero", ONE, ONE, 3'd6, 1'b0);
        send_one("op7_zero", TWO, ONE, 3'd7, 1'b0);

        // Back-to-back with a stalled consumer
        out_ready = 1'b0;
        in_a = TWO; in_b = ONE; op = 3'd1; in_valid = 1'b1;
        cycle();
        in_a = ONE; in_b = TWO; op = 3'd1;
        cycle();
        in_a = M_ONE; in_b = M_Z; op = 3'd3;
        check("b2b_in_ready_low", 32'(in_ready), 32'd0);
        check("b2b_out_valid", 32'(out_valid), 32'd1);
        check("b2b_first", 32'(out_result), 32'd1);
        held = out_result;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("b2b_hold_valid", 32'(out_valid), 32'd1);
            check("b2b_hold_result", 32'(out_result), 32'(held));
            check("b2b_hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10 && (in_valid || exp_q.size() != 0); i++) begin
            cycle();
            if (last_acc) in_valid = 1'b0;
        end
        check("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Reset with two transfers in flight
        out_ready = 1'b0;
        in_a = TWO; in_b = ONE; op = 3'd0; in_valid = 1'b1;
        cycle();
        cycle();
        in_valid = 1'b0;
        check("rst_mid_full", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_out_result", 32'(out_result), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("rst_no_stale", 32'(out_valid), 32'd0);
        end

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 600; i++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_a = rand_operand();
                case ($urandom_range(0, 4))
                    0:       in_b = in_a;
                    1:       in_b = in_a ^ (W'(1) << (W - 3));
                    default: in_b = rand_operand();
                endcase
                op = 3'($urandom_range(0, 7));
            end
            out_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) cycle();
        check("final_drain", 32'(exp_q.size()), 32'd0);
        check("final_idle", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
